// File: rtl/hazard_ctrl_v2_if.sv
// Hazard controller bundle: operand/forwarding/miss inputs and
// the per-boundary stall/flush and forward-select outputs.
interface hazard_ctrl_v2_if #(
    parameter int REG_AW = 5,
    parameter int NFWD   = 3,
    parameter int SELW   = $clog2(NFWD + 1)
);
    logic                   id_need_rs1;
    logic                   id_need_rs2;
    logic [REG_AW-1:0]      id_rs1;
    logic [REG_AW-1:0]      id_rs2;
    logic [NFWD-1:0]        fwd_we;
    logic [NFWD*REG_AW-1:0] fwd_rdst;
    logic                   src0_is_load;
    logic                   redirect;
    logic                   i_ICache_Miss;
    logic                   i_DCache_Miss;
    logic [SELW-1:0]        op1_sel;
    logic [SELW-1:0]        op2_sel;
    logic [4:0]             stall;
    logic [4:0]             flush;
    logic                   busy;

    modport master (
        output id_need_rs1, id_need_rs2, id_rs1, id_rs2,
        output fwd_we, fwd_rdst, src0_is_load, redirect,
        output i_ICache_Miss, i_DCache_Miss,
        input  op1_sel, op2_sel, stall, flush, busy
    );

    modport slave (
        input  id_need_rs1, id_need_rs2, id_rs1, id_rs2,
        input  fwd_we, fwd_rdst, src0_is_load, redirect,
        input  i_ICache_Miss, i_DCache_Miss,
        output op1_sel, op2_sel, stall, flush, busy
    );
endinterface

// File: rtl/hazard_ctrl_v2.sv
// 5-stage hazard controller: forwarding select, load-use interlock, miss freeze,
// redirect flush. Define HAZ_PERF_EN to add saturating performance counters.
module hazard_ctrl_v2 #(
    parameter int REG_AW    = 5,
    parameter int NFWD      = 3,
    parameter int LU_STALL  = 1,
    parameter int FLUSH_LEN = 1,
    parameter int SELW      = $clog2(NFWD + 1)
) (
    input  logic clk,
    input  logic rst,
    hazard_ctrl_v2_if.slave hif
`ifdef HAZ_PERF_EN
    ,
    output logic [31:0] perf_stall_cyc,
    output logic [31:0] perf_lu_cnt,
    output logic [31:0] perf_redir_cnt
`endif
);
    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] LU    = 2'd1;
    localparam logic [1:0] DMISS = 2'd2;
    localparam logic [1:0] FLUSH = 2'd3;

    localparam logic [1:0] LU_RLD = 2'(LU_STALL > 1 ? LU_STALL - 2 : 0);
    localparam logic [1:0] FL_RLD = 2'(FLUSH_LEN > 1 ? FLUSH_LEN - 2 : 0);

    localparam logic [4:0] ST_DM = 5'b01111;
    localparam logic [4:0] FL_DM = 5'b10000;
    localparam logic [4:0] FL_RD = 5'b00110;
    localparam logic [4:0] ST_LU = 5'b00011;
    localparam logic [4:0] FL_LU = 5'b00100;
    localparam logic [4:0] ST_IM = 5'b00001;
    localparam logic [4:0] FL_IM = 5'b00010;

    logic [1:0]        state, state_n;
    logic [1:0]        cnt, cnt_n;
    logic              pend, pend_n;
    logic [4:0]        stall_c, flush_c;
    logic [SELW-1:0]   sel1, sel2;
    logic [REG_AW-1:0] rdst0;
    logic              lu_hit, dmiss;
    logic              run_eval, redir_eff;
    logic              redir_take, lu_take;

    assign dmiss = hif.i_DCache_Miss;
    assign rdst0 = hif.fwd_rdst[REG_AW-1:0];

    // Descending scan so the nearest matching source wins.
    always_comb begin
        sel1 = '0;
        sel2 = '0;
        for (int k = NFWD - 1; k >= 0; k--) begin
            if (hif.fwd_we[k] && hif.id_need_rs1 && hif.id_rs1 != '0 &&
                hif.fwd_rdst[k*REG_AW +: REG_AW] == hif.id_rs1)
                sel1 = SELW'(k + 1);
            if (hif.fwd_we[k] && hif.id_need_rs2 && hif.id_rs2 != '0 &&
                hif.fwd_rdst[k*REG_AW +: REG_AW] == hif.id_rs2)
                sel2 = SELW'(k + 1);
        end
    end

    assign lu_hit = hif.src0_is_load && hif.fwd_we[0] &&
        ((hif.id_need_rs1 && hif.id_rs1 != '0 && hif.id_rs1 == rdst0) ||
         (hif.id_need_rs2 && hif.id_rs2 != '0 && hif.id_rs2 == rdst0));

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        pend_n     = pend;
        stall_c    = '0;
        flush_c    = '0;
        run_eval   = 1'b0;
        redir_eff  = hif.redirect;
        redir_take = 1'b0;
        lu_take    = 1'b0;
        unique case (state)
            RUN: run_eval = 1'b1;
            LU: begin
                if (dmiss || hif.redirect) begin
                    run_eval = 1'b1;
                end else begin
                    stall_c = ST_LU;
                    flush_c = FL_LU;
                    if (cnt == 2'd0) state_n = RUN;
                    else cnt_n = cnt - 2'd1;
                end
            end
            FLUSH: begin
                if (dmiss || hif.redirect) begin
                    run_eval = 1'b1;
                end else begin
                    flush_c = FL_IM;
                    if (cnt == 2'd0) state_n = RUN;
                    else cnt_n = cnt - 2'd1;
                end
            end
            DMISS: begin
                if (dmiss) begin
                    stall_c = ST_DM;
                    flush_c = FL_DM;
                    pend_n  = pend | hif.redirect;
                end else begin
                    // Exit cycle behaves as RUN with the deferred redirect folded in.
                    run_eval  = 1'b1;
                    redir_eff = hif.redirect | pend;
                end
            end
        endcase
        if (run_eval) begin
            state_n = RUN;
            pend_n  = 1'b0;
            if (dmiss) begin
                stall_c = ST_DM;
                flush_c = FL_DM;
                state_n = DMISS;
                pend_n  = hif.redirect;
            end else if (redir_eff) begin
                flush_c    = FL_RD;
                redir_take = 1'b1;
                if (FLUSH_LEN > 1) begin
                    state_n = FLUSH;
                    cnt_n   = FL_RLD;
                end
            end else if (lu_hit) begin
                stall_c = ST_LU;
                flush_c = FL_LU;
                lu_take = 1'b1;
                if (LU_STALL > 1) begin
                    state_n = LU;
                    cnt_n   = LU_RLD;
                end
            end else if (hif.i_ICache_Miss) begin
                stall_c = ST_IM;
                flush_c = FL_IM;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= 2'd0;
            pend  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            pend  <= pend_n;
        end
    end

    assign hif.stall   = rst ? 5'b00000 : stall_c;
    assign hif.flush   = rst ? 5'b11111 : flush_c;
    assign hif.op1_sel = rst ? '0 : sel1;
    assign hif.op2_sel = rst ? '0 : sel2;
    assign hif.busy    = !rst && (state != RUN);

`ifdef HAZ_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cyc <= '0;
            perf_lu_cnt    <= '0;
            perf_redir_cnt <= '0;
        end else begin
            if (stall_c[0] && perf_stall_cyc != '1)
                perf_stall_cyc <= perf_stall_cyc + 32'd1;
            if (lu_take && perf_lu_cnt != '1)
                perf_lu_cnt <= perf_lu_cnt + 32'd1;
            if (redir_take && perf_redir_cnt != '1)
                perf_redir_cnt <= perf_redir_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_hazard_ctrl_v2.sv
// Bench for hazard_ctrl_v2: directed scenarios plus random traffic
// checked against a cycle-count reference model.
module tb_hazard_ctrl_v2;
    localparam int AW  = 5;
    localparam int NF  = 3;
    localparam int LUS = 2;
    localparam int FLN = 3;
    localparam int SW  = $clog2(NF + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_ctrl_v2_if #(.REG_AW(AW), .NFWD(NF)) hif();

`ifdef HAZ_PERF_EN
    logic [31:0] perf_stall_cyc, perf_lu_cnt, perf_redir_cnt;
`endif

    hazard_ctrl_v2 #(
        .REG_AW(AW), .NFWD(NF), .LU_STALL(LUS), .FLUSH_LEN(FLN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hif(hif)
`ifdef HAZ_PERF_EN
        ,
        .perf_stall_cyc(perf_stall_cyc),
        .perf_lu_cnt(perf_lu_cnt),
        .perf_redir_cnt(perf_redir_cnt)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    bit m_dmiss, m_pend;
    int lu_left, fl_left;
    logic [4:0]    e_stall, e_flush;
    logic          e_busy;
    logic [SW-1:0] e_sel1, e_sel2;

    function automatic int fwd_pick(logic need, logic [AW-1:0] rs);
        if (!need || rs == 0) return 0;
        for (int k = 0; k < NF; k++)
            if (hif.fwd_we[k] && hif.fwd_rdst[k*AW +: AW] == rs) return k + 1;
        return 0;
    endfunction

    // Remaining-cycle model: one call per clock, with current inputs.
    function automatic void model_step();
        logic dm, rd, re, lh, run;
        logic [AW-1:0] r0;
        dm = hif.i_DCache_Miss;
        rd = hif.redirect;
        r0 = hif.fwd_rdst[AW-1:0];
        lh = hif.src0_is_load && hif.fwd_we[0] &&
             ((hif.id_need_rs1 && hif.id_rs1 != 0 && hif.id_rs1 == r0) ||
              (hif.id_need_rs2 && hif.id_rs2 != 0 && hif.id_rs2 == r0));
        e_stall = 5'b0;
        e_flush = 5'b0;
        e_busy  = m_dmiss || lu_left > 0 || fl_left > 0;
        e_sel1  = SW'(fwd_pick(hif.id_need_rs1, hif.id_rs1));
        e_sel2  = SW'(fwd_pick(hif.id_need_rs2, hif.id_rs2));
        if (rst) begin
            e_flush = 5'b11111;
            e_busy = 1'b0;
            e_sel1 = '0;
            e_sel2 = '0;
            m_dmiss = 0; m_pend = 0; lu_left = 0; fl_left = 0;
            return;
        end
        re = rd;
        run = 1'b1;
        if (m_dmiss) begin
            if (dm) begin
                e_stall = 5'b01111; e_flush = 5'b10000;
                m_pend = m_pend | rd;
                run = 1'b0;
            end else begin
                re = rd | m_pend;
                m_pend = 0;
                m_dmiss = 0;
            end
        end else if (lu_left > 0) begin
            if (!dm && !rd) begin
                e_stall = 5'b00011; e_flush = 5'b00100;
                lu_left--;
                run = 1'b0;
            end else lu_left = 0;
        end else if (fl_left > 0) begin
            if (!dm && !rd) begin
                e_flush = 5'b00010;
                fl_left--;
                run = 1'b0;
            end else fl_left = 0;
        end
        if (run) begin
            if (dm) begin
                e_stall = 5'b01111; e_flush = 5'b10000;
                m_dmiss = 1; m_pend = rd;
            end else if (re) begin
                e_flush = 5'b00110;
                fl_left = FLN - 1;
            end else if (lh) begin
                e_stall = 5'b00011; e_flush = 5'b00100;
                lu_left = LUS - 1;
            end else if (hif.i_ICache_Miss) begin
                e_stall = 5'b00001; e_flush = 5'b00010;
            end
        end
    endfunction

    task automatic set_idle();
        hif.id_need_rs1 = 0; hif.id_need_rs2 = 0;
        hif.id_rs1 = '0; hif.id_rs2 = '0;
        hif.fwd_we = '0; hif.fwd_rdst = '0;
        hif.src0_is_load = 0; hif.redirect = 0;
        hif.i_ICache_Miss = 0; hif.i_DCache_Miss = 0;
    endtask

    task automatic set_load_use(logic [AW-1:0] r);
        hif.src0_is_load = 1;
        hif.fwd_we = 3'b001;
        hif.fwd_rdst = '0;
        hif.fwd_rdst[AW-1:0] = r;
        hif.id_need_rs1 = 1;
        hif.id_rs1 = r;
    endtask

    task automatic settle();
        @(negedge clk);
        model_step();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(int n);
        set_idle();
        for (int i = 0; i < n; i++) begin
            settle();
            advance();
        end
    endtask

    task automatic test_reset();
        rst = 1;
        hif.id_need_rs1 = 1; hif.id_rs1 = 5'd4;
        hif.fwd_we = 3'b111; hif.fwd_rdst = {3{5'd4}};
        hif.src0_is_load = 1; hif.redirect = 1;
        hif.i_ICache_Miss = 1; hif.i_DCache_Miss = 1;
        hif.id_need_rs2 = 0; hif.id_rs2 = '0;
        settle();
        vectors++;
        if (hif.stall !== 5'b0) begin
            miscompares++;
            $display("FAIL rst_stall got %b want %b", hif.stall, 5'b0);
        end
        vectors++;
        if (hif.flush !== 5'b11111) begin
            miscompares++;
            $display("FAIL rst_flush got %b want %b", hif.flush, 5'b11111);
        end
        vectors++;
        if (hif.busy !== 1'b0 || hif.op1_sel !== '0) begin
            miscompares++;
            $display("FAIL rst_busy_sel got %b/%0d want 0/0", hif.busy, hif.op1_sel);
        end
        advance();
        rst = 0;
        set_idle();
        settle();
        vectors++;
        if ({hif.busy, hif.stall, hif.flush} !== 11'b0) begin
            miscompares++;
            $display("FAIL post_rst_idle got %b want 0",
                     {hif.busy, hif.stall, hif.flush});
        end
        advance();
    endtask

    task automatic test_forwarding();
        set_idle();
        hif.fwd_we = 3'b110;
        hif.fwd_rdst = {5'd5, 5'd5, 5'd9};
        hif.id_need_rs1 = 1; hif.id_rs1 = 5'd5;
        hif.id_need_rs2 = 1; hif.id_rs2 = 5'd9;
        settle();
        vectors++;
        if (hif.op1_sel !== 2'd2 || hif.op2_sel !== 2'd0) begin
            miscompares++;
            $display("FAIL fwd_basic got %0d/%0d want 2/0", hif.op1_sel, hif.op2_sel);
        end
        advance();
        hif.fwd_we = 3'b111;
        hif.fwd_rdst = {5'd5, 5'd0, 5'd9};
        hif.id_rs1 = 5'd0;
        settle();
        vectors++;
        if (hif.op1_sel !== 2'd0 || hif.op2_sel !== 2'd1) begin
            miscompares++;
            $display("FAIL fwd_r0 got %0d/%0d want 0/1", hif.op1_sel, hif.op2_sel);
        end
        advance();
        for (int i = 0; i < 60; i++) begin
            hif.fwd_we = NF'($urandom);
            hif.fwd_rdst = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                            5'($urandom_range(0, 3))};
            hif.id_rs1 = 5'($urandom_range(0, 3));
            hif.id_rs2 = 5'($urandom_range(0, 3));
            hif.id_need_rs1 = 1'($urandom);
            hif.id_need_rs2 = 1'($urandom);
            settle();
            vectors++;
            if (hif.op1_sel !== e_sel1 || hif.op2_sel !== e_sel2) begin
                miscompares++;
                $display("FAIL fwd_rand got %0d/%0d want %0d/%0d",
                         hif.op1_sel, hif.op2_sel, e_sel1, e_sel2);
            end
            advance();
        end
        idle_cycles(2);
    endtask

    task automatic test_load_use();
        set_idle();
        set_load_use(5'd7);
        for (int c = 1; c <= LUS; c++) begin
            settle();
            vectors++;
            if (hif.stall !== 5'b00011 || hif.flush !== 5'b00100 ||
                hif.busy !== (c > 1)) begin
                miscompares++;
                $display("FAIL lu_cyc%0d got %b/%b/%b want 00011/00100/%0d",
                         c, hif.stall, hif.flush, hif.busy, c > 1);
            end
            advance();
        end
        set_idle();
        settle();
        vectors++;
        if ({hif.busy, hif.stall, hif.flush} !== 11'b0) begin
            miscompares++;
            $display("FAIL lu_exit got %b want 0", {hif.busy, hif.stall, hif.flush});
        end
        advance();
    endtask

    task automatic test_dmiss_redirect();
        set_idle();
        for (int c = 1; c <= 4; c++) begin
            hif.i_DCache_Miss = 1;
            hif.redirect = (c == 2);
            settle();
            vectors++;
            if (hif.stall !== 5'b01111 || hif.flush !== 5'b10000 ||
                hif.busy !== (c > 1)) begin
                miscompares++;
                $display("FAIL dmiss_cyc%0d got %b/%b/%b want 01111/10000/%0d",
                         c, hif.stall, hif.flush, hif.busy, c > 1);
            end
            advance();
        end
        set_idle();
        settle();
        vectors++;
        if (hif.stall !== 5'b0 || hif.flush !== 5'b00110) begin
            miscompares++;
            $display("FAIL dmiss_exit got %b/%b want 00000/00110", hif.stall, hif.flush);
        end
        advance();
        idle_cycles(FLN);
        hif.i_DCache_Miss = 1;
        settle();
        advance();
        set_idle();
        settle();
        vectors++;
        if (hif.flush !== 5'b0 || hif.stall !== 5'b0) begin
            miscompares++;
            $display("FAIL pend_clear got %b/%b want 0/0", hif.stall, hif.flush);
        end
        advance();
    endtask

    task automatic test_redirect_vs_lu();
        set_idle();
        set_load_use(5'd3);
        hif.redirect = 1;
        hif.i_ICache_Miss = 1;
        settle();
        vectors++;
        if (hif.stall !== 5'b0 || hif.flush !== 5'b00110) begin
            miscompares++;
            $display("FAIL redir_vs_lu got %b/%b want 00000/00110", hif.stall, hif.flush);
        end
        advance();
        set_idle();
        settle();
        vectors++;
        if (hif.stall !== 5'b0 || hif.flush !== 5'b00010) begin
            miscompares++;
            $display("FAIL redir_no_lu got %b/%b want 00000/00010", hif.stall, hif.flush);
        end
        advance();
        idle_cycles(FLN);
    endtask

    task automatic test_flush_reset();
        set_idle();
        hif.redirect = 1;
        for (int c = 1; c <= FLN + 1; c++) begin
            settle();
            vectors++;
            if (hif.flush[1] !== (c <= FLN)) begin
                miscompares++;
                $display("FAIL flush_len_cyc%0d got %b want %0d", c, hif.flush[1], c <= FLN);
            end
            advance();
            hif.redirect = 0;
        end
        hif.redirect = 1;
        settle();
        advance();
        hif.redirect = 0;
        rst = 1;
        settle();
        vectors++;
        if (hif.flush !== 5'b11111 || hif.stall !== 5'b0 || hif.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_rst got %b/%b/%b want 11111/00000/0",
                     hif.flush, hif.stall, hif.busy);
        end
        advance();
        rst = 0;
        settle();
        vectors++;
        if ({hif.busy, hif.stall, hif.flush} !== 11'b0) begin
            miscompares++;
            $display("FAIL flush_rst_release got %b want 0",
                     {hif.busy, hif.stall, hif.flush});
        end
        advance();
    endtask

    task automatic test_random();
        logic [14:0] got, exp;
        for (int i = 0; i < 500; i++) begin
            rst = ($urandom_range(0, 99) < 2);
            hif.fwd_we = NF'($urandom);
            hif.fwd_rdst = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                            5'($urandom_range(0, 3))};
            hif.id_rs1 = 5'($urandom_range(0, 3));
            hif.id_rs2 = 5'($urandom_range(0, 3));
            hif.id_need_rs1 = 1'($urandom);
            hif.id_need_rs2 = 1'($urandom);
            hif.src0_is_load = ($urandom_range(0, 99) < 40);
            hif.redirect = ($urandom_range(0, 99) < 12);
            hif.i_ICache_Miss = ($urandom_range(0, 99) < 20);
            hif.i_DCache_Miss = hif.i_DCache_Miss ? ($urandom_range(0, 99) < 60)
                                                  : ($urandom_range(0, 99) < 10);
            settle();
            got = {hif.op1_sel, hif.op2_sel, hif.stall, hif.flush, hif.busy};
            exp = {e_sel1, e_sel2, e_stall, e_flush, e_busy};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL rand_%0d got %b want %b", i, got, exp);
            end
            advance();
        end
        rst = 0;
        idle_cycles(FLN + 2);
    endtask

`ifdef HAZ_PERF_EN
    task automatic test_perf();
        set_idle();
        rst = 1;
        settle();
        advance();
        rst = 0;
        hif.i_ICache_Miss = 1;
        for (int i = 0; i < 10; i++) begin
            settle();
            advance();
        end
        set_idle();
        set_load_use(5'd7);
        settle();
        advance();
        idle_cycles(LUS + 1);
        vectors++;
        if (perf_stall_cyc !== 32'(10 + LUS) || perf_lu_cnt !== 32'd1 ||
            perf_redir_cnt !== 32'd0) begin
            miscompares++;
            $display("FAIL perf_cnt got %0d/%0d/%0d want %0d/1/0",
                     perf_stall_cyc, perf_lu_cnt, perf_redir_cnt, 10 + LUS);
        end
        hif.redirect = 1;
        settle();
        advance();
        idle_cycles(FLN);
        vectors++;
        if (perf_redir_cnt !== 32'd1) begin
            miscompares++;
            $display("FAIL perf_redir got %0d want 1", perf_redir_cnt);
        end
    endtask
`endif

    initial begin
        rst = 1;
        set_idle();
        test_reset();
        test_forwarding();
        test_load_use();
        test_dmiss_redirect();
        test_redirect_vs_lu();
        test_flush_reset();
        test_random();
`ifdef HAZ_PERF_EN
        test_perf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
